// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable in, counters, prefetch coordinates,
// sync/blank and line/frame pulses out.
interface vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
);
    logic          ce;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic [HW-1:0] fetch_x;
    logic [VW-1:0] fetch_y;
    logic          fetch_valid;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          line_pulse;
    logic          frame_pulse;

    modport master (
        input  ce,
        output hpos, vpos, fetch_x, fetch_y, fetch_valid,
               hsync, vsync, active, line_pulse, frame_pulse
    );

    modport slave (
        output ce,
        input  hpos, vpos, fetch_x, fetch_y, fetch_valid,
               hsync, vsync, active, line_pulse, frame_pulse
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel enable, sync polarity,
// a look-ahead fetch coordinate and a delay line on sync/active.
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_POL      = 1'b0,
    parameter logic V_POL      = 1'b0,
    parameter int   HW         = 10,
    parameter int   VW         = 10,
    parameter int   PREFETCH   = 2,
    parameter int   PIPE_DELAY = 0
) (
    input logic             clk,
    input logic             nRst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [HW:0]   H_TOT_W  = (HW+1)'(H_TOTAL);
    localparam logic [HW:0]   PF_W     = (HW+1)'(PREFETCH);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_last;
    logic          v_last;
    logic          hs_i;
    logic          vs_i;
    logic          act_i;

    // Pipelines carry active-high decodes; stage 0 is the mandatory register.
    logic [PIPE_DELAY:0] hs_pipe;
    logic [PIPE_DELAY:0] vs_pipe;
    logic [PIPE_DELAY:0] act_pipe;

    logic [HW:0]   fetch_sum;
    logic [HW:0]   fetch_wrap;
    logic [HW-1:0] fetch_x;
    logic [VW-1:0] fetch_y;

    assign h_last = (hcnt == H_LAST);
    assign v_last = (vcnt == V_LAST);
    assign hs_i   = (hcnt >= HS_START) && (hcnt <= HS_END);
    assign vs_i   = (vcnt >= VS_START) && (vcnt <= VS_END);
    assign act_i  = (hcnt < H_VIS) && (vcnt < V_VIS);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (bus.ce) begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hs_pipe  <= '0;
            vs_pipe  <= '0;
            act_pipe <= '0;
        end else if (bus.ce) begin
            hs_pipe[0]  <= hs_i;
            vs_pipe[0]  <= vs_i;
            act_pipe[0] <= act_i;
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                act_pipe[i] <= act_pipe[i-1];
            end
        end
    end

    // The sum is one bit wider so the wrap test cannot overflow.
    always_comb begin
        fetch_sum  = {1'b0, hcnt} + PF_W;
        fetch_wrap = fetch_sum - H_TOT_W;
        if (fetch_sum < H_TOT_W) begin
            fetch_x = fetch_sum[HW-1:0];
            fetch_y = vcnt;
        end else begin
            fetch_x = fetch_wrap[HW-1:0];
            fetch_y = v_last ? '0 : vcnt + VW'(1);
        end
    end

    assign bus.hpos        = hcnt;
    assign bus.vpos        = vcnt;
    assign bus.fetch_x     = fetch_x;
    assign bus.fetch_y     = fetch_y;
    assign bus.fetch_valid = (fetch_x < H_VIS) && (fetch_y < V_VIS);
    assign bus.hsync       = hs_pipe[PIPE_DELAY] ^ ~H_POL;
    assign bus.vsync       = vs_pipe[PIPE_DELAY] ^ ~V_POL;
    assign bus.active      = act_pipe[PIPE_DELAY];
    assign bus.line_pulse  = bus.ce && h_last;
    assign bus.frame_pulse = bus.ce && h_last && v_last;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default mode, delayed/inverted-polarity mode and a tiny
// mode run in lockstep from one clock, enable and reset.
module tb_vga_timing_gen;
    logic clk  = 1'b0;
    logic nRst = 1'b1;
    logic ce   = 1'b0;
    int   t    = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.HW(10), .VW(10)) bus0 ();
    vga_timing_gen_if #(.HW(10), .VW(10)) bus3 ();
    vga_timing_gen_if #(.HW(4),  .VW(4))  bus_s ();

    assign bus0.ce  = ce;
    assign bus3.ce  = ce;
    assign bus_s.ce = ce;

    vga_timing_gen dut0 (.clk(clk), .nRst(nRst), .bus(bus0.master));

    vga_timing_gen #(.PIPE_DELAY(3), .H_POL(1'b1), .V_POL(1'b1))
        dut3 (.clk(clk), .nRst(nRst), .bus(bus3.master));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HW(4), .VW(4))
        dut_s (.clk(clk), .nRst(nRst), .bus(bus_s.master));

    // t counts enabled edges since the last reset release.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (ce && nRst) t++;
            #1;
        end
    endtask

    task automatic goto_t(input int target);
        while (t < target) step(1);
    endtask

    task automatic test_reset;
        nRst = 1'b1;
        ce   = 1'b0;
        #2 nRst = 1'b0;
        #20;
        checks++; if (bus0.hpos !== 10'd0) begin errors++; $display("FAIL reset_hpos: got %0d want 0", bus0.hpos); end
        checks++; if (bus0.vpos !== 10'd0) begin errors++; $display("FAIL reset_vpos: got %0d want 0", bus0.vpos); end
        checks++; if (bus0.hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", bus0.hsync); end
        checks++; if (bus0.vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", bus0.vsync); end
        checks++; if (bus0.active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", bus0.active); end
        checks++; if (bus0.line_pulse !== 1'b0) begin errors++; $display("FAIL reset_line_pulse: got %b want 0", bus0.line_pulse); end
        checks++; if (bus0.fetch_x !== 10'd2) begin errors++; $display("FAIL reset_fetch_x: got %0d want 2", bus0.fetch_x); end
        checks++; if (bus3.hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync_pol1: got %b want 0", bus3.hsync); end
        checks++; if (bus3.vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync_pol1: got %b want 0", bus3.vsync); end
        nRst = 1'b1;
        ce   = 1'b1;
        t    = 0;
    endtask

    task automatic test_startup;
        goto_t(3);
        checks++; if (bus0.hpos !== 10'd3) begin errors++; $display("FAIL start_hpos: got %0d want 3", bus0.hpos); end
        checks++; if (bus0.active !== 1'b1) begin errors++; $display("FAIL start_active_d0: got %b want 1", bus0.active); end
        checks++; if (bus3.active !== 1'b0) begin errors++; $display("FAIL start_active_d3_early: got %b want 0", bus3.active); end
        goto_t(4);
        checks++; if (bus3.active !== 1'b1) begin errors++; $display("FAIL start_active_d3: got %b want 1", bus3.active); end
        checks++; if (bus3.hpos !== 10'd4) begin errors++; $display("FAIL start_hpos_d3: got %0d want 4", bus3.hpos); end
    endtask

    task automatic test_small_mode;
        goto_t(8);
        checks++; if (bus_s.active !== 1'b1) begin errors++; $display("FAIL small_active_on: got %b want 1", bus_s.active); end
        goto_t(9);
        checks++; if (bus_s.active !== 1'b0) begin errors++; $display("FAIL small_active_off: got %b want 0", bus_s.active); end
        goto_t(10);
        checks++; if (bus_s.hsync !== 1'b0) begin errors++; $display("FAIL small_hsync: got %b want 0", bus_s.hsync); end
        goto_t(11);
        checks++; if (bus_s.line_pulse !== 1'b1) begin errors++; $display("FAIL small_line_pulse: got %b want 1", bus_s.line_pulse); end
        checks++; if (bus_s.frame_pulse !== 1'b0) begin errors++; $display("FAIL small_frame_early: got %b want 0", bus_s.frame_pulse); end
        goto_t(12);
        checks++; if (bus_s.hpos !== 4'd0 || bus_s.vpos !== 4'd1) begin errors++; $display("FAIL small_hwrap: got %0d,%0d want 0,1", bus_s.hpos, bus_s.vpos); end
        checks++; if (bus_s.line_pulse !== 1'b0) begin errors++; $display("FAIL small_line_pulse_off: got %b want 0", bus_s.line_pulse); end
        goto_t(60);
        checks++; if (bus_s.vsync !== 1'b1 || bus_s.vpos !== 4'd5) begin errors++; $display("FAIL small_vsync_pre: got %b,%0d want 1,5", bus_s.vsync, bus_s.vpos); end
        goto_t(61);
        checks++; if (bus_s.vsync !== 1'b0) begin errors++; $display("FAIL small_vsync_on: got %b want 0", bus_s.vsync); end
        goto_t(73);
        checks++; if (bus_s.vsync !== 1'b1) begin errors++; $display("FAIL small_vsync_off: got %b want 1", bus_s.vsync); end
        goto_t(82);
        checks++; if (bus_s.fetch_x !== 4'd0 || bus_s.fetch_y !== 4'd0 || bus_s.fetch_valid !== 1'b1) begin errors++; $display("FAIL small_fetch_82: got %0d,%0d,%b want 0,0,1", bus_s.fetch_x, bus_s.fetch_y, bus_s.fetch_valid); end
        goto_t(83);
        checks++; if (bus_s.frame_pulse !== 1'b1) begin errors++; $display("FAIL small_frame_pulse: got %b want 1", bus_s.frame_pulse); end
        checks++; if (bus_s.fetch_x !== 4'd1 || bus_s.fetch_y !== 4'd0 || bus_s.fetch_valid !== 1'b1) begin errors++; $display("FAIL small_fetch_83: got %0d,%0d,%b want 1,0,1", bus_s.fetch_x, bus_s.fetch_y, bus_s.fetch_valid); end
        goto_t(84);
        checks++; if (bus_s.hpos !== 4'd0 || bus_s.vpos !== 4'd0) begin errors++; $display("FAIL small_vwrap: got %0d,%0d want 0,0", bus_s.hpos, bus_s.vpos); end
        goto_t(90);
        checks++; if (bus_s.fetch_x !== 4'd8 || bus_s.fetch_valid !== 1'b0) begin errors++; $display("FAIL small_fetch_edge: got %0d,%b want 8,0", bus_s.fetch_x, bus_s.fetch_valid); end
        goto_t(166);
        checks++; if (bus_s.frame_pulse !== 1'b0) begin errors++; $display("FAIL small_frame_166: got %b want 0", bus_s.frame_pulse); end
        goto_t(167);
        checks++; if (bus_s.frame_pulse !== 1'b1) begin errors++; $display("FAIL small_frame_167: got %b want 1", bus_s.frame_pulse); end
    endtask

    task automatic test_hsync_active;
        goto_t(640);
        checks++; if (bus0.active !== 1'b1) begin errors++; $display("FAIL active_640: got %b want 1", bus0.active); end
        goto_t(641);
        checks++; if (bus0.active !== 1'b0) begin errors++; $display("FAIL active_641: got %b want 0", bus0.active); end
        goto_t(656);
        checks++; if (bus0.hsync !== 1'b1) begin errors++; $display("FAIL hsync_656: got %b want 1", bus0.hsync); end
        goto_t(657);
        checks++; if (bus0.hsync !== 1'b0) begin errors++; $display("FAIL hsync_657: got %b want 0", bus0.hsync); end
        goto_t(659);
        checks++; if (bus3.hsync !== 1'b0) begin errors++; $display("FAIL hsync_d3_659: got %b want 0", bus3.hsync); end
        goto_t(660);
        checks++; if (bus3.hsync !== 1'b1) begin errors++; $display("FAIL hsync_d3_660: got %b want 1", bus3.hsync); end
        goto_t(752);
        checks++; if (bus0.hsync !== 1'b0) begin errors++; $display("FAIL hsync_752: got %b want 0", bus0.hsync); end
        goto_t(753);
        checks++; if (bus0.hsync !== 1'b1) begin errors++; $display("FAIL hsync_753: got %b want 1", bus0.hsync); end
        goto_t(755);
        checks++; if (bus3.hsync !== 1'b1 || bus3.vsync !== 1'b0) begin errors++; $display("FAIL hsync_d3_755: got %b,%b want 1,0", bus3.hsync, bus3.vsync); end
        goto_t(756);
        checks++; if (bus3.hsync !== 1'b0) begin errors++; $display("FAIL hsync_d3_756: got %b want 0", bus3.hsync); end
    endtask

    task automatic test_line_pulse;
        goto_t(798);
        checks++; if (bus0.line_pulse !== 1'b0) begin errors++; $display("FAIL lp_798: got %b want 0", bus0.line_pulse); end
        checks++; if (bus0.fetch_x !== 10'd0 || bus0.fetch_y !== 10'd1 || bus0.fetch_valid !== 1'b1) begin errors++; $display("FAIL fetch_798: got %0d,%0d,%b want 0,1,1", bus0.fetch_x, bus0.fetch_y, bus0.fetch_valid); end
        goto_t(799);
        checks++; if (bus0.line_pulse !== 1'b1 || bus0.frame_pulse !== 1'b0) begin errors++; $display("FAIL lp_799: got %b,%b want 1,0", bus0.line_pulse, bus0.frame_pulse); end
        goto_t(800);
        checks++; if (bus0.hpos !== 10'd0 || bus0.vpos !== 10'd1) begin errors++; $display("FAIL hwrap_800: got %0d,%0d want 0,1", bus0.hpos, bus0.vpos); end
        goto_t(1599);
        checks++; if (bus0.line_pulse !== 1'b1) begin errors++; $display("FAIL lp_1599: got %b want 1", bus0.line_pulse); end
    endtask

    task automatic test_prefetch;
        goto_t(4798);
        checks++; if (bus0.fetch_x !== 10'd0 || bus0.fetch_y !== 10'd6 || bus0.fetch_valid !== 1'b1) begin errors++; $display("FAIL fetch_wrap_line: got %0d,%0d,%b want 0,6,1", bus0.fetch_x, bus0.fetch_y, bus0.fetch_valid); end
        goto_t(8637);
        checks++; if (bus0.fetch_x !== 10'd639 || bus0.fetch_valid !== 1'b1) begin errors++; $display("FAIL fetch_639: got %0d,%b want 639,1", bus0.fetch_x, bus0.fetch_valid); end
        goto_t(8638);
        checks++; if (bus0.fetch_x !== 10'd640 || bus0.fetch_y !== 10'd10 || bus0.fetch_valid !== 1'b0) begin errors++; $display("FAIL fetch_640: got %0d,%0d,%b want 640,10,0", bus0.fetch_x, bus0.fetch_y, bus0.fetch_valid); end
    endtask

    task automatic test_ce_toggle;
        int exp_h;
        int exp_v;
        int pulses_on;
        int pulses_off;
        int bad;
        goto_t(8799);
        checks++; if (bus0.line_pulse !== 1'b1) begin errors++; $display("FAIL ce_lp_on: got %b want 1", bus0.line_pulse); end
        ce = 1'b0;
        #1;
        checks++; if (bus0.line_pulse !== 1'b0) begin errors++; $display("FAIL ce_lp_gated: got %b want 0", bus0.line_pulse); end
        step(1);
        checks++; if (bus0.hpos !== 10'd799 || bus0.vpos !== 10'd10) begin errors++; $display("FAIL ce_hold: got %0d,%0d want 799,10", bus0.hpos, bus0.vpos); end
        ce = 1'b1;
        step(1);
        checks++; if (bus0.hpos !== 10'd0 || bus0.vpos !== 10'd11) begin errors++; $display("FAIL ce_resume: got %0d,%0d want 0,11", bus0.hpos, bus0.vpos); end
        exp_h = 0; exp_v = 11; pulses_on = 0; pulses_off = 0; bad = 0;
        for (int i = 0; i < 1600; i++) begin
            ce = (i % 2) == 1;
            #1;
            if (bus0.line_pulse === 1'b1) begin
                if (ce) pulses_on++;
                else pulses_off++;
            end
            step(1);
            if (ce) begin
                if (exp_h == 799) begin exp_h = 0; exp_v++; end
                else exp_h++;
            end
            if (bus0.hpos !== 10'(exp_h) || bus0.vpos !== 10'(exp_v)) bad++;
        end
        ce = 1'b1;
        checks++; if (bad != 0) begin errors++; $display("FAIL ce_half_rate_track: got %0d bad samples want 0", bad); end
        checks++; if (pulses_on != 1) begin errors++; $display("FAIL ce_half_rate_pulses: got %0d want 1", pulses_on); end
        checks++; if (pulses_off != 0) begin errors++; $display("FAIL ce_pulse_while_off: got %0d want 0", pulses_off); end
        checks++; if (bus0.hpos !== 10'd0 || bus0.vpos !== 10'd12) begin errors++; $display("FAIL ce_end_pos: got %0d,%0d want 0,12", bus0.hpos, bus0.vpos); end
    endtask

    task automatic test_async_reset;
        goto_t(9900);
        checks++; if (bus0.hpos !== 10'd300 || bus0.vpos !== 10'd12) begin errors++; $display("FAIL ar_pre: got %0d,%0d want 300,12", bus0.hpos, bus0.vpos); end
        #2 nRst = 1'b0;
        #1;
        checks++; if (bus0.hpos !== 10'd0 || bus0.vpos !== 10'd0) begin errors++; $display("FAIL ar_counters: got %0d,%0d want 0,0", bus0.hpos, bus0.vpos); end
        checks++; if (bus0.hsync !== 1'b1 || bus0.active !== 1'b0) begin errors++; $display("FAIL ar_sync: got %b,%b want 1,0", bus0.hsync, bus0.active); end
        checks++; if (bus3.hsync !== 1'b0 || bus3.active !== 1'b0) begin errors++; $display("FAIL ar_sync_d3: got %b,%b want 0,0", bus3.hsync, bus3.active); end
        checks++; if (bus_s.hpos !== 4'd0 || bus0.fetch_x !== 10'd2) begin errors++; $display("FAIL ar_small_fetch: got %0d,%0d want 0,2", bus_s.hpos, bus0.fetch_x); end
        step(3);
        checks++; if (bus0.hpos !== 10'd0 || bus0.line_pulse !== 1'b0) begin errors++; $display("FAIL ar_hold: got %0d,%b want 0,0", bus0.hpos, bus0.line_pulse); end
        t = 0;
        nRst = 1'b1;
        step(1);
        checks++; if (bus0.hpos !== 10'd1 || bus0.vpos !== 10'd0) begin errors++; $display("FAIL ar_restart: got %0d,%0d want 1,0", bus0.hpos, bus0.vpos); end
        goto_t(83);
        checks++; if (bus_s.frame_pulse !== 1'b1) begin errors++; $display("FAIL ar_small_frame: got %b want 1", bus_s.frame_pulse); end
        goto_t(799);
        checks++; if (bus0.line_pulse !== 1'b1 || bus0.vpos !== 10'd0) begin errors++; $display("FAIL ar_first_line: got %b,%0d want 1,0", bus0.line_pulse, bus0.vpos); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_small_mode();
        test_hsync_active();
        test_line_pulse();
        test_prefetch();
        test_ce_toggle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
